// File: rtl/bus_arbiter.sv
// Two-master (CPU = m0, DMA = m1) round-robin arbiter in front of a single slave bus.
// Optional watchdog on slave completion is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_done,
  output logic              m1_done,
  output logic              m0_err,
  output logic              m1_err,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s_re,
  output logic              s_we,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              re_q, re_d, we_q, we_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              win;
  logic              fin;
  logic              fin_err;
  logic [DATA_W-1:0] fin_data;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err0_q, err0_d, err1_q, err1_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
      wd_q     <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      re_q     <= re_d;
      we_q     <= we_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef BUS_ARB_TIMEOUT_EN
      wd_q     <= wd_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
`endif
    end
  end

  // On a tie the master that did not win last time goes next.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    re_d     = re_q;
    we_d     = we_q;
    gnt0_d   = gnt0_q;
    gnt1_d   = gnt1_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    win      = (m0_req && m1_req) ? ~last_q : m1_req;
    fin      = 1'b0;
    fin_err  = 1'b0;
    fin_data = '0;
`ifdef BUS_ARB_TIMEOUT_EN
    wd_d     = wd_q;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          owner_d = win;
          last_d  = win;
          addr_d  = win ? m1_addr  : m0_addr;
          wdata_d = win ? m1_wdata : m0_wdata;
          we_d    = win ? m1_we    : m0_we;
          re_d    = win ? ~m1_we   : ~m0_we;
          gnt0_d  = ~win;
          gnt1_d  = win;
          state_d = BUSY;
`ifdef BUS_ARB_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      BUSY: begin
        if (s_ready) begin
          fin      = 1'b1;
          fin_data = we_q ? '0 : s_rdata;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          fin      = 1'b1;
          fin_err  = 1'b1;
          fin_data = '1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Completion (normal or watchdog) releases the bus and loads the owner's result.
    if (fin) begin
      re_d    = 1'b0;
      we_d    = 1'b0;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      state_d = DONE;
      if (owner_q) begin
        done1_d  = 1'b1;
        rdata1_d = fin_data;
      end else begin
        done0_d  = 1'b1;
        rdata0_d = fin_data;
      end
    end
`ifdef BUS_ARB_TIMEOUT_EN
    err0_d = fin & ~owner_q & fin_err;
    err1_d = fin & owner_q & fin_err;
`endif
  end

  assign m0_gnt   = gnt0_q;
  assign m1_gnt   = gnt1_q;
  assign m0_done  = done0_q;
  assign m1_done  = done1_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;
  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign s_re     = re_q;
  assign s_we     = we_q;

`ifdef BUS_ARB_TIMEOUT_EN
  assign m0_err = err0_q;
  assign m1_err = err1_q;
`else
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: scoreboard of expected completions, one task per scenario.
// Exercises the watchdog path when BUS_ARB_TIMEOUT_EN is defined.
module tb_bus_arbiter;
  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 64;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              m0_req, m1_req, m0_we, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic              s_re, s_we, s_ready;
  logic [DATA_W-1:0] s_rdata;

  typedef struct {
    bit                master;
    logic [DATA_W-1:0] rdata;
    bit                err;
  } exp_t;

  exp_t              sb[$];
  int                checks = 0;
  int                fails  = 0;
  logic [DATA_W-1:0] prev_rdata[2];

  bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_done(m0_done), .m1_done(m1_done),
    .m0_err(m0_err), .m1_err(m1_err), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_re(s_re), .s_we(s_we),
    .s_ready(s_ready), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit m, input logic [DATA_W-1:0] r, input bit e);
    exp_t x;
    x.master = m;
    x.rdata  = r;
    x.err    = e;
    sb.push_back(x);
  endtask

  task automatic idle_inputs();
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    s_ready = 0; s_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    prev_rdata[0] = '0;
    prev_rdata[1] = '0;
    tick();
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m0_gnt || m1_gnt) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Holds the strobe for lat cycles, then answers; returns observing the DONE cycle.
  task automatic serve(input int lat, input logic [DATA_W-1:0] rd);
    repeat (lat - 1) tick();
    s_ready = 1'b1;
    s_rdata = rd;
    tick();
    s_ready = 1'b0;
    s_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, s_re, s_we} !== 8'h00) begin
      fails++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000000",
               {m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, s_re, s_we});
    end
    checks++;
    if ({m0_rdata, m1_rdata, s_addr, s_wdata} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_data: got %h %h %h %h expected all 0", m0_rdata, m1_rdata, s_addr, s_wdata);
    end
    reset = 1'b1;
    prev_rdata[0] = '0;
    prev_rdata[1] = '0;
    tick();
    s_ready = 1'b1;
    s_rdata = 64'hDEAD;
    tick();
    s_ready = 1'b0;
    tick();
    checks++;
    if ({m0_gnt, m1_gnt, m0_done, m1_done, s_re, s_we} !== 6'b0 || m0_rdata !== '0) begin
      fails++;
      $display("[TB] FAIL idle_ready_ignored: got ctrl %b rdata %h expected 0 0",
               {m0_gnt, m1_gnt, m0_done, m1_done, s_re, s_we}, m0_rdata);
    end
  endtask

  task automatic test_read();
    exp_t e;
    int re_cycles;
    push_exp(1'b0, 64'h41, 1'b0);
    m0_req = 1; m0_we = 0; m0_addr = 64'h8000_0000;
    tick();
    m0_req = 0;
    checks++;
    if ({m1_gnt, m0_gnt, s_re, s_we} !== 4'b0110 || s_addr !== 64'h8000_0000) begin
      fails++;
      $display("[TB] FAIL read_issue: got gnt/re/we %b addr %h expected 0110 80000000",
               {m1_gnt, m0_gnt, s_re, s_we}, s_addr);
    end
    re_cycles = s_re ? 1 : 0;
    tick();
    if (s_re) re_cycles++;
    tick();
    if (s_re) re_cycles++;
    s_ready = 1; s_rdata = 64'h41;
    tick();
    s_ready = 0; s_rdata = '0;
    checks++;
    if (re_cycles !== 3) begin
      fails++;
      $display("[TB] FAIL read_re_cycles: got %0d expected 3", re_cycles);
    end
    e = sb.pop_front();
    checks++;
    if ({m0_done, m1_done, m0_gnt, s_re} !== 4'b1000 || m0_rdata !== e.rdata || m0_err !== e.err) begin
      fails++;
      $display("[TB] FAIL read_done: got done/gnt/re %b rdata %h err %b expected 1000 %h %b",
               {m0_done, m1_done, m0_gnt, s_re}, m0_rdata, m0_err, e.rdata, e.err);
    end
    prev_rdata[0] = e.rdata;
    tick();
    checks++;
    if (m0_done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL read_done_pulse: got %b expected 0", m0_done);
    end
  endtask

  task automatic test_alternation();
    exp_t e;
    bit ok;
    do_reset();
    push_exp(1'b0, 64'hA0, 1'b0);
    push_exp(1'b1, 64'hB1, 1'b0);
    push_exp(1'b0, 64'hA2, 1'b0);
    m0_req = 1; m1_req = 1; m0_addr = 64'h100; m1_addr = 64'h200;
    for (int i = 0; i < 3; i++) begin
      wait_grant(ok);
      checks++;
      if (!ok) begin
        fails++;
        $display("[TB] FAIL alt_grant_timeout: got no grant expected grant %0d", i);
        break;
      end
      if (i == 2) begin
        m0_req = 0; m1_req = 0;
      end
      checks++;
      if ({m1_gnt, m0_gnt} !== (sb[0].master ? 2'b10 : 2'b01)) begin
        fails++;
        $display("[TB] FAIL alt_owner_%0d: got gnt %b expected master %0d", i, {m1_gnt, m0_gnt}, sb[0].master);
      end
      serve(2, sb[0].rdata);
      e = sb.pop_front();
      prev_rdata[e.master] = e.rdata;
      checks++;
      if ({m1_done, m0_done} !== (e.master ? 2'b10 : 2'b01) ||
          m0_rdata !== prev_rdata[0] || m1_rdata !== prev_rdata[1]) begin
        fails++;
        $display("[TB] FAIL alt_done_%0d: got done %b rdata %h %h expected master %0d rdata %h %h",
                 i, {m1_done, m0_done}, m0_rdata, m1_rdata, e.master, prev_rdata[0], prev_rdata[1]);
      end
      tick();
      checks++;
      if ({m1_gnt, m0_gnt, m1_done, m0_done} !== 4'b0) begin
        fails++;
        $display("[TB] FAIL alt_gap_%0d: got gnt/done %b expected 0000", i, {m1_gnt, m0_gnt, m1_done, m0_done});
      end
    end
  endtask

  task automatic test_write_drop();
    exp_t e;
    bit ok;
    bit stable;
    push_exp(1'b1, '0, 1'b0);
    m1_req = 1; m1_we = 1; m1_addr = 64'h10; m1_wdata = 64'h55;
    wait_grant(ok);
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    checks++;
    if (!ok || {m1_gnt, s_re, s_we} !== 3'b101 || s_addr !== 64'h10 || s_wdata !== 64'h55) begin
      fails++;
      $display("[TB] FAIL write_issue: got gnt/re/we %b addr %h wdata %h expected 101 10 55",
               {m1_gnt, s_re, s_we}, s_addr, s_wdata);
    end
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!(s_we && !s_re && m1_gnt && s_addr == 64'h10 && s_wdata == 64'h55 && !m1_done)) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      fails++;
      $display("[TB] FAIL write_hold: got %b expected 1", stable);
    end
    serve(1, 64'hFFFF);
    e = sb.pop_front();
    prev_rdata[1] = e.rdata;
    checks++;
    if ({m1_done, m0_done, s_we} !== 3'b100 || m1_rdata !== e.rdata || m0_rdata !== prev_rdata[0]) begin
      fails++;
      $display("[TB] FAIL write_done: got done/we %b rdata %h m0 %h expected 100 %h %h",
               {m1_done, m0_done, s_we}, m1_rdata, m0_rdata, e.rdata, prev_rdata[0]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit ok;
    m0_req = 1; m0_we = 0; m0_addr = 64'h20;
    wait_grant(ok);
    m0_req = 0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (!ok || {m0_gnt, m1_gnt, m0_done, m1_done, s_re, s_we} !== 6'b0 ||
        {m0_rdata, m1_rdata, s_addr} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_mid_outputs: got ctrl %b data %h %h %h expected 0",
               {m0_gnt, m1_gnt, m0_done, m1_done, s_re, s_we}, m0_rdata, m1_rdata, s_addr);
    end
    tick();
    checks++;
    if ({m0_done, m1_done} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL reset_mid_nodone: got %b expected 00", {m0_done, m1_done});
    end
    reset = 1'b1;
    prev_rdata[0] = '0;
    prev_rdata[1] = '0;
    push_exp(1'b0, 64'h77, 1'b0);
    m0_req = 1; m1_req = 1;
    tick();
    m0_req = 0; m1_req = 0;
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL reset_mid_tie: got gnt %b expected 01", {m1_gnt, m0_gnt});
    end
    serve(1, 64'h77);
    e = sb.pop_front();
    checks++;
    if (m0_done !== 1'b1 || m0_rdata !== e.rdata) begin
      fails++;
      $display("[TB] FAIL reset_mid_done: got %b %h expected 1 %h", m0_done, m0_rdata, e.rdata);
    end
    tick();
  endtask

`ifdef BUS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    bit ok;
    bit got;
    int busy;
    push_exp(1'b1, '1, 1'b1);
    m1_req = 1; m1_we = 0; m1_addr = 64'h30;
    wait_grant(ok);
    m1_req = 0;
    busy = (ok && m1_gnt) ? 1 : 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m1_done) begin
        got = 1'b1;
        break;
      end
      if (m1_gnt) busy++;
    end
    e = sb.pop_front();
    checks++;
    if (!got || busy !== TIMEOUT) begin
      fails++;
      $display("[TB] FAIL timeout_cycles: got done %b after %0d busy expected 1 after %0d", got, busy, TIMEOUT);
    end
    checks++;
    if (m1_err !== e.err || m1_rdata !== e.rdata || s_re !== 1'b0) begin
      fails++;
      $display("[TB] FAIL timeout_result: got err %b rdata %h re %b expected %b %h 0",
               m1_err, m1_rdata, s_re, e.err, e.rdata);
    end
    tick();
    checks++;
    if ({m1_done, m1_err} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL timeout_pulse: got %b expected 00", {m1_done, m1_err});
    end
  endtask
`else
  task automatic test_timeout();
    exp_t e;
    bit ok;
    bit persist;
    push_exp(1'b0, 64'h99, 1'b0);
    m0_req = 1; m0_we = 0; m0_addr = 64'h30;
    wait_grant(ok);
    m0_req = 0;
    persist = ok;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!(s_re && m0_gnt && !m0_done && !m0_err)) persist = 1'b0;
    end
    checks++;
    if (persist !== 1'b1) begin
      fails++;
      $display("[TB] FAIL busy_persist: got %b expected 1", persist);
    end
    serve(1, 64'h99);
    e = sb.pop_front();
    checks++;
    if (m0_done !== 1'b1 || m0_rdata !== e.rdata || m0_err !== e.err) begin
      fails++;
      $display("[TB] FAIL busy_late_done: got %b %h %b expected 1 %h %b", m0_done, m0_rdata, m0_err, e.rdata, e.err);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_alternation();
    test_write_drop();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64, address width of the master and slave buses.
REQ-002 Parameter DATA_W, default 64, data width of the master and slave buses.
REQ-003 Parameter TIMEOUT, default 15, watchdog limit in cycles; used only when BUS_ARB_TIMEOUT_EN is defined.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 m0_req, m1_req  input  1 each  transaction request; master 0 is the CPU, master 1 is DMA.
REQ-007 m0_we, m1_we  input  1 each  1 = write, 0 = read.
REQ-008 m0_addr, m1_addr  input  ADDR_W each  transaction address.
REQ-009 m0_wdata, m1_wdata  input  DATA_W each  write data.
REQ-010 m0_gnt, m1_gnt  output  1 each  master owns the slave bus.
REQ-011 m0_done, m1_done  output  1 each  one-cycle completion pulse.
REQ-012 m0_err, m1_err  output  1 each  error flag, valid with done.
REQ-013 m0_rdata, m1_rdata  output  DATA_W each  read data, valid with done.
REQ-014 s_addr, s_wdata  output  ADDR_W, DATA_W  slave address and write data.
REQ-015 s_re, s_we  output  1 each  slave read and write strobes.
REQ-016 s_ready  input  1  slave completion.
REQ-017 s_rdata  input  DATA_W  slave read data.

Function
REQ-018 FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-019 IDLE: a sampled request SHALL select a winner, register its addr/wdata/we onto s_*, assert exactly one of s_re/s_we and the winner's gnt, and move to BUSY; s_* SHALL be visible the cycle after request sampling.
REQ-020 Single request: that master SHALL win. Both requesting: the master not recorded in last_grant SHALL win, and last_grant SHALL update to the winner.
REQ-021 BUSY: s_addr, s_wdata and the strobe SHALL stay stable until s_ready=1 is sampled.
REQ-022 On s_ready: strobes SHALL deassert, s_rdata SHALL be latched (reads only, else 0), and the FSM SHALL enter DONE.
REQ-023 DONE: owner's done SHALL pulse for exactly one cycle with rdata/err valid; gnt SHALL drop; FSM SHALL return to IDLE.
REQ-024 Next grant SHALL occur no earlier than one cycle after DONE (IDLE re-arbitrates).
REQ-025 Owner dropping req mid-transaction SHALL NOT abort: the transaction completes and done still pulses.
REQ-026 s_ready in IDLE or DONE SHALL be ignored.
REQ-027 Non-owner rdata SHALL hold its last value; its done/err SHALL stay 0.
REQ-028 At most one gnt and at most one of s_re/s_we SHALL be high in any cycle.

Reset
REQ-029 reset low SHALL immediately force IDLE, all outputs 0, watchdog 0, last_grant=1 (m0 wins the first tie), including mid-transaction, with no done pulse.

Configuration
REQ-030 With BUS_ARB_TIMEOUT_EN defined: a watchdog SHALL count BUSY cycles, and on reaching TIMEOUT without s_ready SHALL deassert strobes, return rdata all-ones, enter DONE, and pulse done with err=1.
REQ-031 Without BUS_ARB_TIMEOUT_EN: BUSY SHALL wait indefinitely and m0_err/m1_err SHALL be tied 0.

Verification
REQ-032 m0 read addr 0x8000_0000, s_ready after 3 cycles with s_rdata 0x41 -> s_re 3 cycles, m0_done pulse, m0_rdata=0x41, m0_err=0.
REQ-033 m0 and m1 request together after reset -> m0 granted first; both held -> m1 next, then m0 (alternation).
REQ-034 m1 write 0x55 to 0x10, m1_req dropped in BUSY -> s_we held until s_ready, m1_done still pulses.
REQ-035 reset asserted during BUSY -> all outputs 0 in the same cycle, no done; after release m0 wins the first tie.
REQ-036 BUS_ARB_TIMEOUT_EN, TIMEOUT=15, s_ready held 0 -> after 15 BUSY cycles done pulses, err=1, rdata=all-ones; macro off -> BUSY persists for 100 cycles.
